// File: rtl/icgtn_multi_ctrl.sv
// rtl/icgtn_multi_ctrl.sv - NCH-channel negative-edge clock gate with wake handshake and idle auto-gate
module icgtn_multi_ctrl #(
   parameter int NCH      = 4,
   parameter int IDLE_W   = 8,
   parameter int WAKE_CYC = 2
) (
   input  logic              CLK,
   input  logic              RN,
   input  logic              TE,
   input  logic [NCH-1:0]    REQ,
   input  logic [NCH-1:0]    BUSY,
   input  logic [IDLE_W-1:0] IDLE_LIMIT,
   output logic [NCH-1:0]    ACK,
   output logic [NCH-1:0]    GATE_ON,
   output logic [NCH-1:0]    GCLKN
);

   typedef enum logic [1:0] {ST_OFF, ST_WAKE, ST_ON, ST_IDLE} state_t;

   localparam logic [3:0]        WAKE_LD  = 4'(WAKE_CYC);
   localparam logic [3:0]        WAKE_ONE = 4'd1;
   localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);

   state_t            state    [NCH];
   state_t            state_nx [NCH];
   logic [3:0]        wake_cnt [NCH];
   logic [3:0]        wake_nx  [NCH];
   logic [IDLE_W-1:0] idle_cnt [NCH];
   logic [IDLE_W-1:0] idle_nx  [NCH];
   logic [NCH-1:0]    en_nx;
   logic [NCH-1:0]    gate_on;
   logic [NCH-1:0]    ack;
   logic [NCH-1:0]    latched;

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         for (int i = 0; i < NCH; i++) begin
            state[i]    <= ST_OFF;
            wake_cnt[i] <= '0;
            idle_cnt[i] <= '0;
         end
         gate_on <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            state[i]    <= state_nx[i];
            wake_cnt[i] <= wake_nx[i];
            idle_cnt[i] <= idle_nx[i];
         end
         gate_on <= en_nx;
      end
   end

   always_comb begin
      en_nx = '0;
      ack   = '0;
      for (int i = 0; i < NCH; i++) begin
         state_nx[i] = state[i];
         wake_nx[i]  = wake_cnt[i];
         idle_nx[i]  = idle_cnt[i];
         case (state[i])
            ST_OFF: begin
               if (REQ[i]) begin
                  state_nx[i] = ST_WAKE;
                  wake_nx[i]  = WAKE_LD;
               end
            end
            ST_WAKE: begin
               // A dropped request abandons the wake and falls into the idle countdown.
               if (!REQ[i]) begin
                  wake_nx[i]  = '0;
                  state_nx[i] = (IDLE_LIMIT == '0) ? ST_OFF : ST_IDLE;
                  idle_nx[i]  = IDLE_LIMIT;
               end else if (wake_cnt[i] <= WAKE_ONE) begin
                  wake_nx[i]  = '0;
                  state_nx[i] = ST_ON;
               end else begin
                  wake_nx[i]  = wake_cnt[i] - WAKE_ONE;
               end
            end
            ST_ON: begin
               if (!REQ[i] && !BUSY[i]) begin
                  state_nx[i] = (IDLE_LIMIT == '0) ? ST_OFF : ST_IDLE;
                  idle_nx[i]  = IDLE_LIMIT;
               end
            end
            ST_IDLE: begin
               if (REQ[i]) begin
                  state_nx[i] = ST_ON;
                  idle_nx[i]  = '0;
               end else if (BUSY[i]) begin
                  idle_nx[i]  = IDLE_LIMIT;
               end else if (idle_cnt[i] <= IDLE_ONE) begin
                  state_nx[i] = ST_OFF;
                  idle_nx[i]  = '0;
               end else begin
                  idle_nx[i]  = idle_cnt[i] - IDLE_ONE;
               end
            end
            default: begin
               state_nx[i] = ST_OFF;
               wake_nx[i]  = '0;
               idle_nx[i]  = '0;
            end
         endcase
         en_nx[i] = (state_nx[i] != ST_OFF);
         ack[i]   = (state[i] == ST_ON);
      end
   end

   // Latch is open while CLK is high so GCLKN's low phase always sees a settled enable;
   // reset also opens it so a stale enable is dropped without waiting for an edge.
   always_latch begin
      if (!RN || CLK)
         latched = {NCH{TE}} | (gate_on & {NCH{RN}});
   end

   assign GCLKN   = {NCH{CLK}} | ~latched;
   assign GATE_ON = gate_on;
   assign ACK     = ack;

endmodule

// File: tb/tb_icgtn_multi_ctrl.sv
// tb/tb_icgtn_multi_ctrl.sv - directed-vector bench for icgtn_multi_ctrl
module tb_icgtn_multi_ctrl;

   logic       CLK = 1'b0;
   logic       RN;
   logic       TE;
   logic [3:0] REQ;
   logic [3:0] BUSY;
   logic [7:0] IDLE_LIMIT;
   logic [3:0] ACK;
   logic [3:0] GATE_ON;
   logic [3:0] GCLKN;

   int vectors     = 0;
   int miscompares = 0;

   icgtn_multi_ctrl #(.NCH(4), .IDLE_W(8), .WAKE_CYC(2)) dut (
      .CLK        (CLK),
      .RN         (RN),
      .TE         (TE),
      .REQ        (REQ),
      .BUSY       (BUSY),
      .IDLE_LIMIT (IDLE_LIMIT),
      .ACK        (ACK),
      .GATE_ON    (GATE_ON),
      .GCLKN      (GCLKN)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic low_phase();
      @(negedge CLK);
      #1;
   endtask

   // Brings channel 1 from OFF to ON (REQ held) and checks the ACK arrives on the third edge.
   task automatic wake_ch1(input string tag);
      REQ[1] = 1'b1;
      tick();
      tick();
      check({tag, "_ack_early"}, ACK, 4'b0000);
      tick();
      check({tag, "_ack"}, ACK, 4'b0010);
   endtask

   initial begin
      RN = 1'b1; TE = 1'b0; REQ = '0; BUSY = '0; IDLE_LIMIT = 8'd5;
      #1 RN = 1'b0;
      #2;
      check("rst_ack",   ACK,     4'b0000);
      check("rst_gate",  GATE_ON, 4'b0000);
      check("rst_gclkn", GCLKN,   4'b1111);
      repeat (2) @(negedge CLK);
      RN = 1'b1;

      // idle with no requests: every gated clock stays high
      for (int c = 0; c < 20; c++) begin
         tick();
         check("idle_gclkn_hi", GCLKN, 4'b1111);
         low_phase();
         check("idle_gclkn_lo", GCLKN, 4'b1111);
         check("idle_ack", ACK, 4'b0000);
      end

      // wake channel 1, REQ driven just after edge n
      tick();
      REQ[1] = 1'b1;
      tick();
      check("wake_gate_n1",  GATE_ON, 4'b0010);
      check("wake_ack_n1",   ACK,     4'b0000);
      check("wake_gclkn_hi", GCLKN,   4'b1111);
      low_phase();
      check("wake_gclkn_lo", GCLKN,   4'b1101);
      tick();
      check("wake_ack_n2",   ACK,     4'b0000);
      tick();
      check("wake_ack_n3",   ACK,     4'b0010);
      check("on_gclkn_hi",   GCLKN,   4'b1111);
      low_phase();
      check("on_gclkn_lo",   GCLKN,   4'b1101);

      // idle timeout with IDLE_LIMIT=5: gate falls 6 edges after the drop
      tick();
      REQ[1] = 1'b0;
      tick();
      check("to_ack_m1",  ACK,     4'b0000);
      check("to_gate_m1", GATE_ON, 4'b0010);
      repeat (4) tick();
      check("to_gate_m5", GATE_ON, 4'b0010);
      tick();
      check("to_gate_m6", GATE_ON, 4'b0000);
      low_phase();
      check("to_gclkn_lo", GCLKN,  4'b1111);

      // BUSY pulse at count 2 reloads to 5
      tick();
      wake_ch1("busy");
      REQ[1] = 1'b0;
      repeat (4) tick();
      BUSY[1] = 1'b1;
      tick();
      BUSY[1] = 1'b0;
      check("busy_ack_idle", ACK, 4'b0000);
      repeat (4) tick();
      check("busy_gate_k4", GATE_ON, 4'b0010);
      tick();
      check("busy_gate_k5", GATE_ON, 4'b0000);

      // IDLE_LIMIT=0 goes straight to OFF
      IDLE_LIMIT = 8'd0;
      wake_ch1("lim0");
      REQ[1] = 1'b0;
      tick();
      check("lim0_gate", GATE_ON, 4'b0000);
      check("lim0_ack",  ACK,     4'b0000);

      // re-request during IDLE at count 4: ACK on the next edge
      IDLE_LIMIT = 8'd10;
      wake_ch1("rereq");
      REQ[1] = 1'b0;
      repeat (7) tick();
      check("rereq_ack_idle",  ACK,     4'b0000);
      check("rereq_gate_idle", GATE_ON, 4'b0010);
      REQ[1] = 1'b1;
      tick();
      check("rereq_ack", ACK, 4'b0010);
      IDLE_LIMIT = 8'd0;
      REQ[1] = 1'b0;
      tick();
      check("rereq_off", GATE_ON, 4'b0000);

      // TE forces all clocks to follow CLK without touching the FSMs
      TE = 1'b1;
      #1;
      check("te_gclkn_hi", GCLKN, 4'b1111);
      low_phase();
      check("te_gclkn_lo", GCLKN,   4'b0000);
      check("te_ack",      ACK,     4'b0000);
      check("te_gate",     GATE_ON, 4'b0000);
      tick();
      check("te_gclkn_hi2", GCLKN, 4'b1111);
      low_phase();
      TE = 1'b0;
      #1;
      check("te_drop_hold", GCLKN, 4'b0000);
      tick();
      check("te_drop_hi", GCLKN, 4'b1111);
      low_phase();
      check("te_drop_lo", GCLKN, 4'b1111);

      // concurrent events: ch2 times out on the edge ch0/ch3 requests are sampled
      IDLE_LIMIT = 8'd3;
      tick();
      REQ[2:1] = 2'b11;
      repeat (3) tick();
      check("multi_ack_setup", ACK, 4'b0110);
      REQ[2] = 1'b0;
      repeat (3) tick();
      check("multi_gate_pre", GATE_ON, 4'b0110);
      REQ[0] = 1'b1;
      REQ[3] = 1'b1;
      tick();
      check("multi_gate_n", GATE_ON, 4'b1011);
      check("multi_ack_n",  ACK,     4'b0010);
      tick();
      check("multi_ack_n1", ACK,     4'b0010);
      tick();
      check("multi_ack_n2", ACK,     4'b1011);
      low_phase();
      check("multi_gclkn_lo", GCLKN, 4'b0100);

      // asynchronous reset in the low phase with channels running
      RN = 1'b0;
      #1;
      check("arst_gclkn", GCLKN,   4'b1111);
      check("arst_ack",   ACK,     4'b0000);
      check("arst_gate",  GATE_ON, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
